// File: rtl/dual_pwm_drive_if.sv
// Command and drive bundle between the direction FSM and the H-bridge driver.
// The driver takes the slave side; the commanding logic takes the master side.
interface dual_pwm_drive_if;
    logic       FWD_A;
    logic       BWD_A;
    logic       FWD_B;
    logic       BWD_B;
    logic [1:0] Duty_SelA;
    logic [1:0] Duty_SelB;
    logic       ENA;
    logic       ENB;
    logic       IN1;
    logic       IN2;
    logic       IN3;
    logic       IN4;
    logic [1:0] DirA;
    logic [1:0] DirB;
    logic       PeriodTick;

    modport master (
        output FWD_A, BWD_A, FWD_B, BWD_B, Duty_SelA, Duty_SelB,
        input  ENA, ENB, IN1, IN2, IN3, IN4, DirA, DirB, PeriodTick
    );

    modport slave (
        input  FWD_A, BWD_A, FWD_B, BWD_B, Duty_SelA, Duty_SelB,
        output ENA, ENB, IN1, IN2, IN3, IN4, DirA, DirB, PeriodTick
    );
endinterface

// File: rtl/dual_pwm_drive.sv
// Two-channel H-bridge driver: shared PWM counter, period-aligned duty,
// and a dead-time FSM per channel that keeps both legs off on reversal.
module dual_pwm_drive #(
    parameter int PWM_PERIOD = 100_000,
    parameter int DEADTIME   = 1_000_000
) (
    input logic             clk,
    input logic             rst,
    dual_pwm_drive_if.slave bus
);

    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam int TW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);

    localparam logic [1:0] S_STOP = 2'b00;
    localparam logic [1:0] S_FWD  = 2'b01;
    localparam logic [1:0] S_BWD  = 2'b10;
    localparam logic [1:0] S_DEAD = 2'b11;

    typedef struct packed {
        logic [1:0]    st;
        logic [1:0]    tgt;
        logic [TW-1:0] tmr;
    } ch_t;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] thr_a;
    logic [CW-1:0] thr_a_n;
    logic [CW-1:0] thr_b;
    logic [CW-1:0] thr_b_n;
    ch_t           a;
    ch_t           a_n;
    ch_t           b;
    ch_t           b_n;

    function automatic logic [CW-1:0] duty_thr(input logic [1:0] code);
        logic [CW-1:0] t;
        case (code)
            2'b00:   t = CW'(PWM_PERIOD / 4);
            2'b01:   t = CW'(PWM_PERIOD / 2);
            2'b10:   t = CW'((3 * PWM_PERIOD) / 4);
            default: t = CW'(PWM_PERIOD);
        endcase
        return t;
    endfunction

    // Illegal both-high request collapses to stop, same as no request.
    function automatic ch_t ch_next(input ch_t cur,
                                    input logic fwd,
                                    input logic bwd);
        ch_t        n;
        logic [1:0] cmd;
        n   = cur;
        cmd = (fwd & ~bwd) ? S_FWD :
              (bwd & ~fwd) ? S_BWD : S_STOP;
        case (cur.st)
            S_STOP: n.st = cmd;
            S_FWD, S_BWD: begin
                if (cmd == S_STOP) begin
                    n.st = S_STOP;
                end else if (cmd != cur.st) begin
                    n.st  = S_DEAD;
                    n.tmr = TW'(DEADTIME - 1);
                    n.tgt = cmd;
                end
            end
            default: begin
                if (cmd == S_STOP) begin
                    n.st  = S_STOP;
                    n.tmr = '0;
                end else if (cur.tmr == '0) begin
                    n.st = (cmd == cur.tgt) ? cur.tgt : S_STOP;
                end else begin
                    n.tmr = cur.tmr - 1'b1;
                    n.tgt = cmd;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic driving(input logic [1:0] st);
        return (st == S_FWD) || (st == S_BWD);
    endfunction

    // Next counter, period-boundary duty latch and channel transitions.
    always_comb begin
        cnt_n   = (cnt == LAST) ? '0 : cnt + 1'b1;
        thr_a_n = thr_a;
        thr_b_n = thr_b;
        if (cnt == LAST) begin
            thr_a_n = duty_thr(bus.Duty_SelA);
            thr_b_n = duty_thr(bus.Duty_SelB);
        end
        a_n = ch_next(a, bus.FWD_A, bus.BWD_A);
        b_n = ch_next(b, bus.FWD_B, bus.BWD_B);
    end

    // Pins register from next state so they line up with DirA/DirB and cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            thr_a          <= '0;
            thr_b          <= '0;
            a              <= '0;
            b              <= '0;
            bus.ENA        <= 1'b0;
            bus.ENB        <= 1'b0;
            bus.IN1        <= 1'b0;
            bus.IN2        <= 1'b0;
            bus.IN3        <= 1'b0;
            bus.IN4        <= 1'b0;
            bus.PeriodTick <= 1'b0;
        end else begin
            cnt            <= cnt_n;
            thr_a          <= thr_a_n;
            thr_b          <= thr_b_n;
            a              <= a_n;
            b              <= b_n;
            bus.ENA        <= driving(a_n.st) && (cnt_n < thr_a_n);
            bus.ENB        <= driving(b_n.st) && (cnt_n < thr_b_n);
            bus.IN1        <= (a_n.st == S_FWD);
            bus.IN2        <= (a_n.st == S_BWD);
            bus.IN3        <= (b_n.st == S_FWD);
            bus.IN4        <= (b_n.st == S_BWD);
            bus.PeriodTick <= (cnt_n == LAST);
        end
    end

    assign bus.DirA = a.st;
    assign bus.DirB = b.st;

endmodule

// File: tb/tb_dual_pwm_drive.sv
// Directed plus randomized bench for dual_pwm_drive against a
// cycle-count based behavioural model (PWM_PERIOD=8, DEADTIME=5).
module tb_dual_pwm_drive;

    localparam int P = 8;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Model: elapsed cycles since reset, per-channel mode
    // (0 stop, 1 fwd, 2 bwd, 3 dead), dead cycles left, pending target.
    int m_cyc = 0;
    int m_thr[2];
    int m_mode[2];
    int m_left[2];
    int m_tgt[2];

    dual_pwm_drive_if bus ();

    dual_pwm_drive #(
        .PWM_PERIOD(P),
        .DEADTIME  (D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int cmd_of(input logic f, input logic b);
        if (f && !b) return 1;
        if (b && !f) return 2;
        return 0;
    endfunction

    function automatic int duty_of(input logic [1:0] code);
        return (P * (int'(code) + 1)) / 4;
    endfunction

    task automatic model_step();
        int cmd[2];
        if (rst) begin
            m_cyc = 0;
            for (int c = 0; c < 2; c++) begin
                m_thr[c]  = 0;
                m_mode[c] = 0;
                m_left[c] = 0;
                m_tgt[c]  = 0;
            end
        end else begin
            cmd[0] = cmd_of(bus.FWD_A, bus.BWD_A);
            cmd[1] = cmd_of(bus.FWD_B, bus.BWD_B);
            if (m_cyc % P == P - 1) begin
                m_thr[0] = duty_of(bus.Duty_SelA);
                m_thr[1] = duty_of(bus.Duty_SelB);
            end
            m_cyc++;
            for (int c = 0; c < 2; c++) begin
                if (m_mode[c] == 0) begin
                    m_mode[c] = cmd[c];
                end else if (m_mode[c] != 3) begin
                    if (cmd[c] == 0) begin
                        m_mode[c] = 0;
                    end else if (cmd[c] != m_mode[c]) begin
                        m_mode[c] = 3;
                        m_left[c] = D;
                        m_tgt[c]  = cmd[c];
                    end
                end else if (cmd[c] == 0) begin
                    m_mode[c] = 0;
                end else if (m_left[c] == 1) begin
                    m_mode[c] = (cmd[c] == m_tgt[c]) ? m_tgt[c] : 0;
                end else begin
                    m_left[c]--;
                    m_tgt[c] = cmd[c];
                end
            end
        end
    endtask

    function automatic logic [10:0] model_outs();
        logic       en[2];
        int         cnt;
        logic [1:0] da;
        logic [1:0] db;
        cnt = m_cyc % P;
        for (int c = 0; c < 2; c++)
            en[c] = (m_mode[c] == 1 || m_mode[c] == 2) && (cnt < m_thr[c]);
        da = 2'(m_mode[0]);
        db = 2'(m_mode[1]);
        return {en[0], en[1],
                m_mode[0] == 1, m_mode[0] == 2,
                m_mode[1] == 1, m_mode[1] == 2,
                da, db, cnt == P - 1};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {bus.ENA, bus.ENB, bus.IN1, bus.IN2, bus.IN3, bus.IN4,
                bus.DirA, bus.DirB, bus.PeriodTick};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: model advances with the DUT, outputs compared at negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("outs", 32'(dut_outs()), 32'(model_outs()));
        chk("legs", 32'((bus.IN1 & bus.IN2) | (bus.IN3 & bus.IN4)), 32'd0);
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (bus.PeriodTick !== 1'b1 && n < 3 * P) begin
            cyc();
            n++;
        end
        chk(tag, 32'(bus.PeriodTick), 32'd1);
    endtask

    initial begin
        int hi;
        int dead;
        int n;
        int hold;

        bus.FWD_A     = 1'b0;
        bus.BWD_A     = 1'b0;
        bus.FWD_B     = 1'b0;
        bus.BWD_B     = 1'b0;
        bus.Duty_SelA = 2'b00;
        bus.Duty_SelB = 2'b00;
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_outs", 32'(dut_outs()), 32'd0);
        rst = 1'b0;

        // Forward at half duty.
        bus.FWD_A     = 1'b1;
        bus.Duty_SelA = 2'b01;
        cyc();
        chk("fwd_pins", 32'({bus.IN1, bus.IN2, bus.DirA}), 32'b1001);
        wait_tick("t1_tick");
        hi = 0;
        for (int k = 0; k < 2 * P; k++) begin
            cyc();
            chk("t1_phase", 32'(bus.ENA), 32'((k % P) < P / 2));
            hi += int'(bus.ENA);
        end
        chk("t1_high", 32'(hi), 32'(P));

        // Reversal to backward.
        bus.FWD_A = 1'b0;
        bus.BWD_A = 1'b1;
        dead = 0;
        n = 0;
        do begin
            cyc();
            n++;
            if (bus.DirA == 2'b11) begin
                dead++;
                chk("t2_off", 32'({bus.IN1, bus.IN2, bus.ENA}), 32'd0);
            end
        end while (bus.DirA != 2'b10 && n < 4 * D);
        chk("t2_dead", 32'(dead), 32'(D));
        chk("t2_bwd", 32'({bus.IN1, bus.IN2}), 32'b01);

        // Duty change on channel B mid-period.
        bus.FWD_B = 1'b1;
        cyc();
        wait_tick("t3_tick");
        wait_tick("t3_tick2");
        hi = 0;
        for (int k = 0; k < 2 * P; k++) begin
            cyc();
            if (k == 3) bus.Duty_SelB = 2'b10;
            hi += int'(bus.ENB);
            if (k == P - 1) begin
                chk("t3_cur", 32'(hi), 32'd2);
                hi = 0;
            end
        end
        chk("t3_next", 32'(hi), 32'd6);

        // Both requests from forward act as stop; then full duty.
        bus.BWD_A = 1'b0;
        cyc();
        bus.FWD_A = 1'b1;
        cyc();
        chk("t4_fwd", 32'(bus.DirA), 32'b01);
        bus.BWD_A = 1'b1;
        cyc();
        chk("t4_stop", 32'({bus.DirA, bus.IN1, bus.IN2, bus.ENA}), 32'd0);
        bus.BWD_A     = 1'b0;
        bus.Duty_SelA = 2'b11;
        cyc();
        wait_tick("t4_tick");
        cyc();
        for (int k = 0; k < P + 4; k++) begin
            cyc();
            chk("t4_full", 32'(bus.ENA), 32'd1);
        end

        // Stop request while dead-time is running.
        bus.FWD_A = 1'b0;
        bus.BWD_A = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("t5_dead", 32'(bus.DirA), 32'b11);
        bus.BWD_A = 1'b0;
        cyc();
        chk("t5_stop", 32'(bus.DirA), 32'b00);

        // Toggle B, F, B inside dead-time: full dead-time still applies.
        bus.FWD_A = 1'b1;
        cyc();
        dead = 0;
        bus.FWD_A = 1'b0;
        bus.BWD_A = 1'b1;
        cyc();
        dead += int'(bus.DirA == 2'b11);
        bus.FWD_A = 1'b1;
        bus.BWD_A = 1'b0;
        cyc();
        dead += int'(bus.DirA == 2'b11);
        bus.FWD_A = 1'b0;
        bus.BWD_A = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
            dead += int'(bus.DirA == 2'b11);
        end while (bus.DirA == 2'b11 && n < 4 * D);
        chk("t5_toggle", 32'(dead), 32'(D));
        chk("t5_bwd", 32'(bus.DirA), 32'b10);

        // Reset in the middle of channel B dead-time.
        bus.FWD_B = 1'b0;
        bus.BWD_B = 1'b1;
        cyc();
        cyc();
        chk("t6_dead", 32'(bus.DirB), 32'b11);
        rst = 1'b1;
        cyc();
        chk("t6_rst", 32'(dut_outs()), 32'd0);
        rst = 1'b0;
        n = 1;
        while (bus.PeriodTick !== 1'b1 && n < 3 * P) begin
            cyc();
            n++;
        end
        chk("t6_tick", 32'(n), 32'(P));

        // Randomized commands, duties and occasional resets.
        for (int s = 0; s < 150; s++) begin
            {bus.FWD_A, bus.BWD_A, bus.FWD_B, bus.BWD_B} = 4'($urandom);
            bus.Duty_SelA = 2'($urandom);
            bus.Duty_SelB = 2'($urandom);
            rst  = ($urandom_range(0, 39) == 0);
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold; k++) begin
                cyc();
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
